// File: rtl/knn_cluster_scheduler_if.sv
// rtl/knn_cluster_scheduler_if.sv - query control and cluster datapath signals of the KNN scheduler
interface knn_cluster_scheduler_if #(
    parameter int SIZE       = 32,
    parameter int CLSTR_SIZE = 2,
    parameter int ARRAY_SIZE = 6
);
    localparam int IDX_W = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;

    logic                                 start;
    logic                                 busy;
    logic                                 chunk_valid;
    logic [IDX_W-1:0]                     base_idx;
    logic [CLSTR_SIZE-1:0]                lane_mask;
    logic                                 dst_valid;
    logic [CLSTR_SIZE-1:0][SIZE-1:0]      dst_in;
    logic                                 done;
    logic [IDX_W-1:0]                     best_idx;
    logic [SIZE-1:0]                      best_dst;

    // Query controller / datapath side
    modport master (
        output start, dst_valid, dst_in,
        input  busy, chunk_valid, base_idx, lane_mask, done, best_idx, best_dst
    );

    // Scheduler side
    modport slave (
        input  start, dst_valid, dst_in,
        output busy, chunk_valid, base_idx, lane_mask, done, best_idx, best_dst
    );
endinterface

// File: rtl/knn_cluster_scheduler.sv
// rtl/knn_cluster_scheduler.sv - chunked nearest-point search sequencer for the KNN distance cluster
module knn_cluster_scheduler #(
    parameter int SIZE       = 32,
    parameter int CLSTR_SIZE = 2,
    parameter int ARRAY_SIZE = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    knn_cluster_scheduler_if.slave    bus
);
    localparam int IDX_W   = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;
    localparam int N_CHUNK = (ARRAY_SIZE + CLSTR_SIZE - 1) / CLSTR_SIZE;
    localparam int CHUNK_W = (N_CHUNK > 1) ? $clog2(N_CHUNK) : 1;
    localparam logic [CHUNK_W-1:0] LAST_CHUNK = CHUNK_W'(N_CHUNK - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_CMP   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]                       state_q, state_d;
    logic [CHUNK_W-1:0]               chunk_q, chunk_d;
    logic                             first_q, first_d;
    logic [CLSTR_SIZE-1:0][SIZE-1:0]  dst_q, dst_d;
    logic [IDX_W-1:0]                 base_idx_q, base_idx_d;
    logic [CLSTR_SIZE-1:0]            lane_mask_q, lane_mask_d;
    logic [IDX_W-1:0]                 best_idx_q, best_idx_d;
    logic [SIZE-1:0]                  best_dst_q, best_dst_d;

    logic [IDX_W-1:0]                 cmp_idx;
    logic [SIZE-1:0]                  cmp_dst;
    logic                             cmp_first;

    // Lanes beyond the end of the point array are disabled
    function automatic logic [CLSTR_SIZE-1:0] mask_for(input int chunk);
        logic [CLSTR_SIZE-1:0] m;
        for (int i = 0; i < CLSTR_SIZE; i++) begin
            m[i] = ((chunk * CLSTR_SIZE + i) < ARRAY_SIZE);
        end
        return m;
    endfunction

    function automatic logic [IDX_W-1:0] base_for(input int chunk);
        return IDX_W'(chunk * CLSTR_SIZE);
    endfunction

    // Running-minimum update over the captured chunk; ascending scan with strict
    // less-than so that ties keep the lower index
    always_comb begin
        cmp_idx   = best_idx_q;
        cmp_dst   = best_dst_q;
        cmp_first = first_q;
        for (int i = 0; i < CLSTR_SIZE; i++) begin
            if (lane_mask_q[i] && (cmp_first || (dst_q[i] < cmp_dst))) begin
                cmp_idx   = IDX_W'(int'(base_idx_q) + i);
                cmp_dst   = dst_q[i];
                cmp_first = 1'b0;
            end
        end
    end

    // Next-state logic for the sequencing FSM and its data registers
    always_comb begin
        state_d     = state_q;
        chunk_d     = chunk_q;
        first_d     = first_q;
        dst_d       = dst_q;
        base_idx_d  = base_idx_q;
        lane_mask_d = lane_mask_q;
        best_idx_d  = best_idx_q;
        best_dst_d  = best_dst_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    chunk_d     = '0;
                    first_d     = 1'b1;
                    base_idx_d  = base_for(0);
                    lane_mask_d = mask_for(0);
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.dst_valid) begin
                    dst_d   = bus.dst_in;
                    state_d = S_CMP;
                end
            end
            S_CMP: begin
                best_idx_d = cmp_idx;
                best_dst_d = cmp_dst;
                first_d    = cmp_first;
                if (chunk_q == LAST_CHUNK) begin
                    state_d = S_DONE;
                end else begin
                    chunk_d     = chunk_q + 1'b1;
                    base_idx_d  = base_for(int'(chunk_q) + 1);
                    lane_mask_d = mask_for(int'(chunk_q) + 1);
                    state_d     = S_ISSUE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; asynchronous reset abandons any query in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            chunk_q     <= '0;
            first_q     <= 1'b0;
            dst_q       <= '0;
            base_idx_q  <= '0;
            lane_mask_q <= '0;
            best_idx_q  <= '0;
            best_dst_q  <= '1;
        end else begin
            state_q     <= state_d;
            chunk_q     <= chunk_d;
            first_q     <= first_d;
            dst_q       <= dst_d;
            base_idx_q  <= base_idx_d;
            lane_mask_q <= lane_mask_d;
            best_idx_q  <= best_idx_d;
            best_dst_q  <= best_dst_d;
        end
    end

    assign bus.busy        = (state_q != S_IDLE);
    assign bus.chunk_valid = (state_q == S_ISSUE);
    assign bus.done        = (state_q == S_DONE);
    assign bus.base_idx    = base_idx_q;
    assign bus.lane_mask   = lane_mask_q;
    assign bus.best_idx    = best_idx_q;
    assign bus.best_dst    = best_dst_q;
endmodule

// File: tb/tb_knn_cluster_scheduler.sv
// tb/tb_knn_cluster_scheduler.sv - directed self-checking bench for knn_cluster_scheduler
module tb_knn_cluster_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    knn_cluster_scheduler_if #(.SIZE(32), .CLSTR_SIZE(2), .ARRAY_SIZE(6)) a_if ();
    knn_cluster_scheduler_if #(.SIZE(32), .CLSTR_SIZE(2), .ARRAY_SIZE(5)) b_if ();

    knn_cluster_scheduler #(.SIZE(32), .CLSTR_SIZE(2), .ARRAY_SIZE(6)) u_a (
        .clk (clk),
        .rst (rst),
        .bus (a_if.slave)
    );

    knn_cluster_scheduler #(.SIZE(32), .CLSTR_SIZE(2), .ARRAY_SIZE(5)) u_b (
        .clk (clk),
        .rst (rst),
        .bus (b_if.slave)
    );

    int checks   = 0;
    int failures = 0;
    logic [31:0] vec [6];
    int  lat;
    int  n_issue;
    bit  seen;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] exp_mask(input int base, input int n);
        logic [1:0] m;
        m[0] = (base < n);
        m[1] = (base + 1 < n);
        return m;
    endfunction

    // Caller raises a_if.start just before; k counts cycles after the start-sampling edge
    task automatic run_a(input int stall, input bit spur, output int lat_o, output int nis_o, output bit seen_o);
        int  k;
        int  ch;
        int  wcnt;
        bit  in_wait;
        k = 0; ch = 0; wcnt = 0; in_wait = 0; seen_o = 0; nis_o = 0; lat_o = 0;
        while (!seen_o && k < 200) begin
            @(posedge clk); #1;
            k++;
            a_if.start     = 1'b0;
            a_if.dst_valid = 1'b0;
            if (a_if.chunk_valid) begin
                nis_o++;
                check_eq("issue_base", a_if.base_idx, 64'(ch * 2));
                check_eq("issue_mask", a_if.lane_mask, exp_mask(ch * 2, 6));
                in_wait = 1; wcnt = 0;
                if (spur) begin
                    a_if.dst_valid = 1'b1;
                    a_if.dst_in    = '0;
                end
            end else if (in_wait) begin
                check_eq("wait_cv", a_if.chunk_valid, 0);
                check_eq("wait_base", a_if.base_idx, 64'(ch * 2));
                check_eq("wait_mask", a_if.lane_mask, exp_mask(ch * 2, 6));
                if (wcnt == stall) begin
                    a_if.dst_valid = 1'b1;
                    a_if.dst_in    = {vec[ch*2+1], vec[ch*2]};
                    in_wait = 0;
                    ch++;
                end else begin
                    wcnt++;
                    if (spur) a_if.start = 1'b1;
                end
            end else if (a_if.done) begin
                seen_o = 1;
                lat_o  = k;
            end else if (spur) begin
                a_if.dst_valid = 1'b1;
                a_if.dst_in    = '0;
            end
        end
        a_if.start     = 1'b0;
        a_if.dst_valid = 1'b0;
        check_eq("done_seen", seen_o, 1);
    endtask

    task automatic run_b(output int lat_o, output int nis_o, output bit seen_o);
        int k;
        int ch;
        bit in_wait;
        k = 0; ch = 0; in_wait = 0; seen_o = 0; nis_o = 0; lat_o = 0;
        while (!seen_o && k < 200) begin
            @(posedge clk); #1;
            k++;
            b_if.start     = 1'b0;
            b_if.dst_valid = 1'b0;
            if (b_if.chunk_valid) begin
                nis_o++;
                check_eq("b_issue_base", b_if.base_idx, 64'(ch * 2));
                check_eq("b_issue_mask", b_if.lane_mask, exp_mask(ch * 2, 5));
                in_wait = 1;
            end else if (in_wait) begin
                b_if.dst_valid = 1'b1;
                b_if.dst_in    = {vec[ch*2+1], vec[ch*2]};
                in_wait = 0;
                ch++;
            end else if (b_if.done) begin
                seen_o = 1;
                lat_o  = k;
            end
        end
        b_if.dst_valid = 1'b0;
        check_eq("b_done_seen", seen_o, 1);
    endtask

    initial begin
        a_if.start = 1'b0; a_if.dst_valid = 1'b0; a_if.dst_in = '0;
        b_if.start = 1'b0; b_if.dst_valid = 1'b0; b_if.dst_in = '0;

        // Reset state
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_busy", a_if.busy, 0);
        check_eq("rst_cv", a_if.chunk_valid, 0);
        check_eq("rst_done", a_if.done, 0);
        check_eq("rst_base", a_if.base_idx, 0);
        check_eq("rst_mask", a_if.lane_mask, 0);
        check_eq("rst_bidx", a_if.best_idx, 0);
        check_eq("rst_bdst", a_if.best_dst, 64'hFFFF_FFFF);
        check_eq("rst_b_bdst", b_if.best_dst, 64'hFFFF_FFFF);
        rst = 1'b1;
        @(posedge clk); #1;

        // dst_valid in IDLE is ignored
        a_if.dst_valid = 1'b1; a_if.dst_in = '0;
        @(posedge clk); #1;
        a_if.dst_valid = 1'b0;
        check_eq("idle_dv_busy", a_if.busy, 0);
        check_eq("idle_dv_bdst", a_if.best_dst, 64'hFFFF_FFFF);
        @(posedge clk); #1;

        // Nominal query
        vec = '{32'd10, 32'd7, 32'd9, 32'd3, 32'd3, 32'd12};
        a_if.start = 1'b1;
        run_a(0, 0, lat, n_issue, seen);
        check_eq("nom_lat", lat, 10);
        check_eq("nom_issue", n_issue, 3);
        check_eq("nom_bidx", a_if.best_idx, 3);
        check_eq("nom_bdst", a_if.best_dst, 3);
        @(posedge clk); #1;
        check_eq("nom_done_pulse", a_if.done, 0);
        check_eq("nom_idle_busy", a_if.busy, 0);
        @(posedge clk); #1;
        check_eq("nom_hold_bidx", a_if.best_idx, 3);
        check_eq("nom_hold_bdst", a_if.best_dst, 3);

        // Stalled datapath: 5 extra WAIT cycles per chunk
        a_if.start = 1'b1;
        run_a(5, 0, lat, n_issue, seen);
        check_eq("stall_lat", lat, 25);
        check_eq("stall_issue", n_issue, 3);
        check_eq("stall_bidx", a_if.best_idx, 3);
        check_eq("stall_bdst", a_if.best_dst, 3);
        repeat (2) @(posedge clk); #1;

        // Spurious start in WAIT and dst_valid in ISSUE/CMP
        a_if.start = 1'b1;
        run_a(2, 1, lat, n_issue, seen);
        check_eq("spur_lat", lat, 16);
        check_eq("spur_issue", n_issue, 3);
        check_eq("spur_bidx", a_if.best_idx, 3);
        check_eq("spur_bdst", a_if.best_dst, 3);
        @(posedge clk); #1;
        check_eq("spur_no_restart", a_if.busy, 0);
        @(posedge clk); #1;

        // Reset during the second WAIT
        a_if.start = 1'b1;
        @(posedge clk); #1;            // ISSUE chunk 0
        a_if.start = 1'b0;
        @(posedge clk); #1;            // WAIT chunk 0
        a_if.dst_valid = 1'b1; a_if.dst_in = {32'd1, 32'd2};
        @(posedge clk); #1;            // CMP chunk 0
        a_if.dst_valid = 1'b0;
        @(posedge clk); #1;            // ISSUE chunk 1
        @(posedge clk); #1;            // WAIT chunk 1
        check_eq("mid_busy_pre", a_if.busy, 1);
        rst = 1'b0;
        #1;
        check_eq("mid_busy", a_if.busy, 0);
        check_eq("mid_base", a_if.base_idx, 0);
        check_eq("mid_mask", a_if.lane_mask, 0);
        check_eq("mid_bidx", a_if.best_idx, 0);
        check_eq("mid_bdst", a_if.best_dst, 64'hFFFF_FFFF);
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check_eq("mid_no_done", a_if.done, 0);
        end
        a_if.start = 1'b1;
        run_a(0, 0, lat, n_issue, seen);
        check_eq("post_rst_lat", lat, 10);
        check_eq("post_rst_bidx", a_if.best_idx, 3);
        check_eq("post_rst_bdst", a_if.best_dst, 3);
        repeat (2) @(posedge clk); #1;

        // All-max distances
        vec = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        a_if.start = 1'b1;
        run_a(0, 0, lat, n_issue, seen);
        check_eq("max_bidx", a_if.best_idx, 0);
        check_eq("max_bdst", a_if.best_dst, 64'hFFFF_FFFF);
        repeat (2) @(posedge clk); #1;

        // Partial last chunk on the 5-point instance; masked lane carries 0
        vec = '{32'd8, 32'd6, 32'd5, 32'd9, 32'd4, 32'd0};
        b_if.start = 1'b1;
        run_b(lat, n_issue, seen);
        check_eq("b_lat", lat, 10);
        check_eq("b_issue", n_issue, 3);
        check_eq("b_bidx", b_if.best_idx, 4);
        check_eq("b_bdst", b_if.best_dst, 4);
        @(posedge clk); #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/knn_cluster_scheduler.md
Name: knn_cluster_scheduler

Overview:
Sequencing controller for the KNN distance cluster. On a start request it walks the point array in chunks of CLSTR_SIZE and issues each chunk's base index and lane mask to the cluster datapath. For each chunk it waits for the returned lane distances and keeps a running minimum. It then reports the nearest point index and its distance with a one-cycle done pulse. It sits between the top-level query control and the cluster of Distance units, with one chunk outstanding at a time.

Parameters:
SIZE, 32, width of one distance value (unsigned)
CLSTR_SIZE, 2, number of parallel distance lanes per chunk
ARRAY_SIZE, 6, number of reference points in the array
IDX_W, derived = max(1, $clog2(ARRAY_SIZE)), point index width (localparam)
N_CHUNK, derived = ceil(ARRAY_SIZE/CLSTR_SIZE), chunks per query (localparam)

Ports:
clk  in  1  single clock, all state rising-edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
start  in  1  begin a query; sampled only in IDLE
busy  out  1  high in every state except IDLE
chunk_valid  out  1  one-cycle pulse: base_idx/lane_mask valid for the datapath
base_idx  out  IDX_W  index of lane 0 of the current chunk (chunk*CLSTR_SIZE)
lane_mask  out  CLSTR_SIZE  bit i = 1 if point base_idx+i < ARRAY_SIZE
dst_valid  in  1  datapath result strobe; sampled only in WAIT
dst_in  in  CLSTR_SIZE x SIZE  lane distances, lane i belongs to point base_idx+i
done  out  1  one-cycle pulse, query complete
best_idx  out  IDX_W  index of nearest point
best_dst  out  SIZE  distance of nearest point

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; busy=0, chunk_valid=0, done=0, base_idx=0, lane_mask=0, best_idx=0, best_dst=all ones; chunk counter=0; internal distance register cleared. Reset mid-query abandons the query and produces no done.
- FSM states: IDLE, ISSUE, WAIT, CMP, DONE.
- IDLE: when start=1, clear chunk counter, set the first-hit flag, go to ISSUE. When start=0, stay. best_idx/best_dst hold their last result.
- ISSUE (1 cycle): chunk_valid=1, base_idx=chunk*CLSTR_SIZE, lane_mask computed as above; next state is WAIT.
- WAIT: hold base_idx/lane_mask stable with chunk_valid=0. On dst_valid=1, register dst_in and go to CMP. There is no timeout; the FSM waits indefinitely.
- CMP (1 cycle): scan lanes 0..CLSTR_SIZE-1 in ascending order, skipping masked lanes.
  - Lane replaces best if the first-hit flag is set (then clear the flag) or its distance is strictly less than best_dst.
  - Ties keep the lower index.
  - Compare is unsigned, full SIZE width, with no saturation.
  - Then, if chunk == N_CHUNK-1, go to DONE; otherwise increment chunk and go to ISSUE.
- DONE (1 cycle): done=1, busy=1, then go to IDLE. best_idx/best_dst are final from this cycle and hold until the next start's first CMP.
- Latency: start sampled at cycle t. With dst_valid asserted in the first WAIT cycle, each chunk costs 3 cycles (ISSUE, WAIT, CMP), so done=1 at cycle t+1+3*N_CHUNK.
- Ignored inputs:
  - start while busy is ignored and not queued.
  - dst_valid outside WAIT is ignored.
- Partial last chunk: lanes past ARRAY_SIZE-1 are masked. Their dst_in values never affect the result, including value 0.
- Chunk counter: never exceeds N_CHUNK-1. base_idx never exceeds (N_CHUNK-1)*CLSTR_SIZE.
- An all-ones distance is still a valid result via the first-hit flag; best_idx is then the first unmasked index, 0.

Test Plan:
- Nominal query: defaults, start at t; return dst_in {lane0,lane1} = {10,7}, {9,3}, {3,12} immediately each WAIT -> base_idx sequence 0,2,4; done at t+10; best_idx=3, best_dst=3 (tie with index 4 lost).
- Partial chunk: ARRAY_SIZE=5, CLSTR_SIZE=2; returns {8,6}, {5,9}, {4,0} -> third chunk lane_mask=2'b01; best_idx=4, best_dst=4 (masked lane value 0 ignored).
- Stalled datapath: dst_valid delayed 5 cycles per chunk -> chunk_valid pulses exactly once per chunk; base_idx/lane_mask stable during WAIT; done at t+1+3*3+15; result matches the nominal query.
- Spurious inputs: start pulsed during WAIT and dst_valid pulsed during ISSUE/CMP/IDLE -> no extra chunk issued, no restart, result unchanged.
- Reset mid-query: rst=0 during second WAIT -> outputs return to reset values immediately; no done; a fresh start then completes a full 3-chunk query correctly.
- All-max distances: every dst_in = 32'hFFFFFFFF -> best_idx=0, best_dst=32'hFFFFFFFF, done asserted.
